key_debounce: RTL

- Multi-key debouncer that consumes the slow divided square wave `clk1` from the clock-divider stage.
- `clk1` is used only as a sampling strobe, never as a clock. Every block register is clocked by the system clock `clk`.
- Outputs are a clean level per key plus one-cycle press, release and long-press pulses for downstream control logic.

---
 rtl/key_db_pkg.sv | 18 +
 rtl/key_db_cell.sv | 123 ++++++++++++
 rtl/key_debounce.sv | 52 +++++
 3 files changed

// File: rtl/key_db_pkg.sv
// Shared types and sizing helpers for the multi-key debouncer.
package key_db_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } key_fsm_e;

  // Width that holds both the stability count and the saturated hold count.
  function automatic int cnt_width(input int stable_samples, input int long_ticks);
    int m;
    m = (stable_samples > long_ticks) ? stable_samples : long_ticks;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/key_db_cell.sv
// One key: 2-flop synchronizer, debounce FSM, hold counter and registered pulses.
// Outputs change 1 clk after the accepting sample strobe; there is no backpressure.
module key_db_cell
  import key_db_pkg::*;
#(
  parameter int ACTIVE_LOW     = 1,
  parameter int STABLE_SAMPLES = 3,
  parameter int LONG_TICKS     = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en,
  input  logic key_raw,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int              CW        = cnt_width(STABLE_SAMPLES, LONG_TICKS);
  localparam logic            IDLE_LVL  = (ACTIVE_LOW != 0);
  localparam logic [CW-1:0]   STABLE_M1 = CW'(STABLE_SAMPLES - 1);
  localparam logic [CW-1:0]   LONG_N    = CW'(LONG_TICKS);

  logic          sync1_q;
  logic          sync2_q;
  logic          k;
  key_fsm_e      state_q;
  logic [CW-1:0] chk_cnt_q;
  logic [CW-1:0] hold_cnt_q;
  logic          key_state_q;
  logic          press_q;
  logic          release_q;
  logic          long_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= IDLE_LVL;
      sync2_q <= IDLE_LVL;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
    end
  end

  // k is 1 when the key is physically pressed, independent of polarity.
  assign k = sync2_q ^ IDLE_LVL;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RELEASED;
      chk_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      key_state_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      if (sample_en) begin
        case (state_q)
          RELEASED: begin
            if (k) begin
              state_q   <= PRESS_CHK;
              chk_cnt_q <= CW'(1);
            end
          end
          PRESS_CHK: begin
            if (!k) begin
              state_q   <= RELEASED;
              chk_cnt_q <= '0;
            end else if (chk_cnt_q == STABLE_M1) begin
              state_q     <= PRESSED;
              key_state_q <= 1'b1;
              press_q     <= 1'b1;
              chk_cnt_q   <= '0;
              hold_cnt_q  <= '0;
            end else begin
              chk_cnt_q <= chk_cnt_q + 1'b1;
            end
          end
          PRESSED: begin
            if (!k) begin
              state_q   <= RELEASE_CHK;
              chk_cnt_q <= CW'(1);
            end else if (hold_cnt_q < LONG_N) begin
              // Saturating at LONG_N guarantees a single long pulse per press.
              hold_cnt_q <= hold_cnt_q + 1'b1;
              if (hold_cnt_q == LONG_N - 1'b1) begin
                long_q <= 1'b1;
              end
            end
          end
          RELEASE_CHK: begin
            if (k) begin
              state_q   <= PRESSED;
              chk_cnt_q <= '0;
            end else if (chk_cnt_q == STABLE_M1) begin
              state_q     <= RELEASED;
              key_state_q <= 1'b0;
              release_q   <= 1'b1;
              chk_cnt_q   <= '0;
              hold_cnt_q  <= '0;
            end else begin
              chk_cnt_q <= chk_cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= RELEASED;
          end
        endcase
      end
    end
  end

  assign key_state   = key_state_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer: clk1 rising edge is a sample strobe, all state runs on clk.
// Pulses appear 1 clk after the accepting strobe; no backpressure, keys are independent.
module key_debounce
  import key_db_pkg::*;
#(
  parameter int NUM_KEYS       = 4,
  parameter int ACTIVE_LOW     = 1,
  parameter int STABLE_SAMPLES = 3,
  parameter int LONG_TICKS     = 50
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk1,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  logic clk1_q;
  logic sample_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk1_q <= 1'b0;
    end else begin
      clk1_q <= clk1;
    end
  end

  // clk1 is a data signal here; its rising edge becomes a one-clk enable.
  assign sample_en = clk1 & ~clk1_q;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_db_cell #(
      .ACTIVE_LOW     (ACTIVE_LOW),
      .STABLE_SAMPLES (STABLE_SAMPLES),
      .LONG_TICKS     (LONG_TICKS)
    ) u_cell (
      .clk         (clk),
      .rst         (rst),
      .sample_en   (sample_en),
      .key_raw     (key_in[i]),
      .key_state   (key_state[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i]),
      .key_long    (key_long[i])
    );
  end

endmodule
